// File: rtl/fmdll_div_counter.sv
// rtl/fmdll_div_counter.sv - FMDLL divider/counter stage in the clk_out domain
// Optional build macro: FMDLL_DIV_REALIGN_EN (force N_counter to 0 at each group boundary)

module fmdll_div_counter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_out,
   input  logic       rst,
   input  logic       clk_ext,
   input  logic       en,
   input  logic [3:0] N,
   input  logic [1:0] M,
   output logic       DIV_N,
   output logic       DIV_M,
   output logic [3:0] N_counter,
   output logic [1:0] M_counter,
   output logic       freq_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIGN = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic [3:0]             r_n_cnt;
   logic [1:0]             r_m_cnt;
   logic [3:0]             r_n_eff;
   logic [1:0]             r_m_eff;
   logic                   r_div_n;
   logic                   r_div_m;
   logic                   r_freq_err;

   logic                   w_ext_rise;
   logic [3:0]             w_n_live;
   logic [1:0]             w_m_live;
   logic [3:0]             w_n_nxt;
   logic [1:0]             w_m_nxt;
   logic [3:0]             w_n_eff_nxt;
   logic [1:0]             w_m_eff_nxt;
   logic                   w_boundary;
   logic                   w_period_ok;

   // DIV_N is high for the first half (rounded up) of the output-cycle count
   function automatic logic f_div_n(input logic [3:0] cnt, input logic [3:0] eff);
      logic [4:0] half;
      half = ({1'b0, eff} + 5'd1) >> 1;
      return ({1'b0, cnt} < half);
   endfunction

   // DIV_M is high for the first half (rounded up) of the group, index starting at 1
   function automatic logic f_div_m(input logic [1:0] cnt, input logic [1:0] eff);
      logic [2:0] half;
      half = ({1'b0, eff} + 3'd1) >> 1;
      return ({1'b0, cnt} <= half);
   endfunction

   assign w_ext_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign w_n_live    = (N == 4'd0) ? 4'd1 : N;
   assign w_m_live    = (M == 2'd0) ? 2'd1 : M;
   assign w_boundary  = w_ext_rise && (r_m_cnt == r_m_eff);
   assign w_period_ok = (r_n_cnt == r_n_eff - 4'd1);

   // Reference clock synchronizer plus history flop for rising-edge detection
   always_ff @(posedge clk_out) begin
      if (rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         if (SYNC_STAGES > 1) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_ext};
         end else begin
            r_sync <= {SYNC_STAGES{clk_ext}};
         end
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   // Next counter and shadow values while running; a >= wrap keeps a counter
   // left above a freshly shrunk n_eff from running off to 15
   always_comb begin
      w_n_nxt     = (r_n_cnt >= r_n_eff - 4'd1) ? 4'd0 : r_n_cnt + 4'd1;
      w_m_nxt     = r_m_cnt;
      w_n_eff_nxt = r_n_eff;
      w_m_eff_nxt = r_m_eff;
      if (w_ext_rise) begin
         if (w_boundary) begin
            w_m_nxt     = 2'd1;
            w_n_eff_nxt = w_n_live;
            w_m_eff_nxt = w_m_live;
`ifdef FMDLL_DIV_REALIGN_EN
            w_n_nxt     = 4'd0;
`endif
         end else begin
            w_m_nxt = r_m_cnt + 2'd1;
         end
      end
   end

   // Control FSM with registered counters, phase flags and mismatch pulse
   always_ff @(posedge clk_out) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_n_cnt    <= 4'd0;
         r_m_cnt    <= 2'd0;
         r_n_eff    <= 4'd1;
         r_m_eff    <= 2'd1;
         r_div_n    <= 1'b0;
         r_div_m    <= 1'b0;
         r_freq_err <= 1'b0;
      end else begin
         r_freq_err <= 1'b0;
         if (!en) begin
            r_state <= S_IDLE;
            r_n_cnt <= 4'd0;
            r_m_cnt <= 2'd0;
            r_n_eff <= w_n_live;
            r_m_eff <= w_m_live;
            r_div_n <= 1'b0;
            r_div_m <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // a reference edge seen on this cycle is deliberately ignored
                  r_state <= S_ALIGN;
                  r_n_cnt <= 4'd0;
                  r_m_cnt <= 2'd0;
                  r_n_eff <= w_n_live;
                  r_m_eff <= w_m_live;
                  r_div_n <= 1'b0;
                  r_div_m <= 1'b0;
               end
               S_ALIGN: begin
                  if (w_ext_rise) begin
                     r_state <= S_RUN;
                     r_n_cnt <= 4'd0;
                     r_m_cnt <= 2'd1;
                     r_n_eff <= w_n_live;
                     r_m_eff <= w_m_live;
                     r_div_n <= f_div_n(4'd0, w_n_live);
                     r_div_m <= f_div_m(2'd1, w_m_live);
                  end
               end
               S_RUN: begin
                  r_n_cnt <= w_n_nxt;
                  r_m_cnt <= w_m_nxt;
                  r_n_eff <= w_n_eff_nxt;
                  r_m_eff <= w_m_eff_nxt;
                  r_div_n <= f_div_n(w_n_nxt, w_n_eff_nxt);
                  r_div_m <= f_div_m(w_m_nxt, w_m_eff_nxt);
                  if (w_ext_rise) begin
                     r_freq_err <= ~w_period_ok;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign DIV_N     = r_div_n;
   assign DIV_M     = r_div_m;
   assign N_counter = r_n_cnt;
   assign M_counter = r_m_cnt;
   assign freq_err  = r_freq_err;

endmodule

// File: tb/tb_fmdll_div_counter.sv
// tb/tb_fmdll_div_counter.sv - randomized self-checking bench for fmdll_div_counter

module tb_fmdll_div_counter;

   localparam int S = 2;

   logic       clk_out = 1'b0;
   logic       rst;
   logic       clk_ext;
   logic       en;
   logic [3:0] N;
   logic [1:0] M;
   logic       DIV_N;
   logic       DIV_M;
   logic [3:0] N_counter;
   logic [1:0] M_counter;
   logic       freq_err;

   wire  [8:0] w_obs = {DIV_N, DIV_M, N_counter, M_counter, freq_err};

   int vectors     = 0;
   int miscompares = 0;

   // reference-clock waveform generator state
   int ext_period = 4;
   int ext_phase  = 0;

   // behavioural model state
   bit h [0:S];
   bit m_run;
   bit m_armed;
   int m_n;
   int m_m;
   int m_neff;
   int m_meff;
   bit m_err;

   fmdll_div_counter #(.SYNC_STAGES(S)) dut (
      .clk_out   (clk_out),
      .rst       (rst),
      .clk_ext   (clk_ext),
      .en        (en),
      .N         (N),
      .M         (M),
      .DIV_N     (DIV_N),
      .DIV_M     (DIV_M),
      .N_counter (N_counter),
      .M_counter (M_counter),
      .freq_err  (freq_err)
   );

   always #5 clk_out = ~clk_out;

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // expected {DIV_N, DIV_M, N_counter, M_counter, freq_err}
   function automatic logic [8:0] exp_vec();
      logic       dn;
      logic       dm;
      logic [3:0] nc;
      logic [1:0] mc;
      dn = m_run && (m_n < (m_neff + 1) / 2);
      dm = m_run && (m_m <= (m_meff + 1) / 2);
      nc = m_run ? 4'(m_n) : 4'd0;
      mc = m_run ? 2'(m_m) : 2'd0;
      return {dn, dm, nc, mc, m_err};
   endfunction

   // one clk_out edge of the specified behaviour: a reference rise is acted
   // on S+1 edges after it is driven
   task automatic model_edge();
      bit rise;
      int pre;
      rise = h[S-1] && !h[S];
      for (int i = S; i > 0; i--) h[i] = h[i-1];
      h[0] = clk_ext;
      m_err = 1'b0;
      if (rst) begin
         for (int i = 0; i <= S; i++) h[i] = 1'b0;
         m_run = 0; m_armed = 0; m_n = 0; m_m = 0;
      end else if (!en) begin
         m_run = 0; m_armed = 0; m_n = 0; m_m = 0;
      end else if (!m_run && !m_armed) begin
         m_armed = 1;
      end else if (m_armed) begin
         if (rise) begin
            m_armed = 0; m_run = 1; m_n = 0; m_m = 1;
            m_neff = eff(int'(N)); m_meff = eff(int'(M));
         end
      end else begin
         pre = m_n;
         m_n = (m_n + 1 >= m_neff) ? 0 : m_n + 1;
         if (rise) begin
            m_err = (pre != m_neff - 1);
            if (m_m == m_meff) begin
               m_m = 1;
               m_neff = eff(int'(N));
               m_meff = eff(int'(M));
`ifdef FMDLL_DIV_REALIGN_EN
               m_n = 0;
`endif
            end else begin
               m_m = m_m + 1;
            end
         end
      end
   endtask

   task automatic tick();
      clk_ext = (ext_phase < (ext_period + 1) / 2);
      ext_phase = (ext_phase + 1) % ext_period;
      @(posedge clk_out);
      model_edge();
      #1;
   endtask

   task automatic restart(input int n_val, input int m_val, input int period);
      en = 1'b0;
      N = 4'(n_val);
      M = 2'(m_val);
      ext_period = period;
      ext_phase = 0;
      tick();
      en = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; N = 4'd4; M = 2'd2;
      ext_period = 2; ext_phase = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (w_obs !== 9'd0) begin
            miscompares++;
            $display("FAIL reset cyc=%0d got=%b exp=%b", i, w_obs, 9'd0);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      int fe_seen;
      fe_seen = 0;
      restart(4, 2, 4);
      for (int i = 0; i < 48; i++) begin
         tick();
         if (freq_err === 1'b1) fe_seen++;
         vectors++;
         if (w_obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL nominal cyc=%0d got=%b exp=%b", i, w_obs, exp_vec());
         end
      end
      vectors++;
      if (fe_seen !== 0) begin
         miscompares++;
         $display("FAIL nominal_freq_err pulses got=%0d exp=0", fe_seen);
      end
   endtask

   task automatic test_mismatch();
      int fe_seen;
      int fe_exp;
      fe_seen = 0; fe_exp = 0;
      restart(4, 2, 5);
      for (int i = 0; i < 60; i++) begin
         tick();
         if (freq_err === 1'b1) fe_seen++;
         if (m_err) fe_exp++;
         vectors++;
         if (w_obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL mismatch cyc=%0d got=%b exp=%b", i, w_obs, exp_vec());
         end
      end
      vectors++;
      if (fe_seen !== fe_exp || fe_exp < 8) begin
         miscompares++;
         $display("FAIL mismatch_pulses got=%0d exp=%0d", fe_seen, fe_exp);
      end
   endtask

   task automatic test_param_change();
      int guard;
      int max_n;
      restart(4, 2, 4);
      guard = 0;
      // let a first group pass, then wait for M_counter=1 mid-group
      for (int i = 0; i < 10; i++) tick();
      while (!(M_counter === 2'd1 && N_counter === 2'd1) && guard < 40) begin
         tick();
         guard++;
      end
      vectors++;
      if (guard >= 40) begin
         miscompares++;
         $display("FAIL param_change_sync timeout got=%0d exp=1", M_counter);
      end
      N = 4'd8;
      max_n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (int'(N_counter) > max_n) max_n = int'(N_counter);
         vectors++;
         if (w_obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL param_change cyc=%0d got=%b exp=%b", i, w_obs, exp_vec());
         end
      end
      vectors++;
      if (max_n !== 7) begin
         miscompares++;
         $display("FAIL param_change_wrap got=%0d exp=7", max_n);
      end
   endtask

   task automatic test_zero();
      restart(0, 0, 3);
      for (int i = 0; i < 30; i++) begin
         tick();
         vectors++;
         if (w_obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL zero cyc=%0d got=%b exp=%b", i, w_obs, exp_vec());
         end
         if (m_run) begin
            vectors++;
            if ({DIV_N, DIV_M, N_counter, M_counter} !== {1'b1, 1'b1, 4'd0, 2'd1}) begin
               miscompares++;
               $display("FAIL zero_run cyc=%0d got=%b exp=%b", i,
                        {DIV_N, DIV_M, N_counter, M_counter}, 8'b11000001);
            end
         end
      end
   endtask

   task automatic test_en_drop();
      int  guard;
      bit  seen_run;
      restart(4, 2, 4);
      guard = 0;
      while (M_counter !== 2'd2 && guard < 40) begin
         tick();
         guard++;
      end
      vectors++;
      if (guard >= 40) begin
         miscompares++;
         $display("FAIL en_drop_sync timeout got=%0d exp=2", M_counter);
      end
      en = 1'b0;
      tick();
      vectors++;
      if (w_obs !== 9'd0) begin
         miscompares++;
         $display("FAIL en_drop_clear got=%b exp=%b", w_obs, 9'd0);
      end
      en = 1'b1;
      seen_run = 0;
      for (int i = 0; i < 20 && !seen_run; i++) begin
         tick();
         vectors++;
         if (m_run) begin
            seen_run = 1;
            if (M_counter !== 2'd1) begin
               miscompares++;
               $display("FAIL en_drop_first got=%0d exp=1", M_counter);
            end
         end else if (M_counter !== 2'd0) begin
            miscompares++;
            $display("FAIL en_drop_wait cyc=%0d got=%0d exp=0", i, M_counter);
         end
      end
      vectors++;
      if (!seen_run) begin
         miscompares++;
         $display("FAIL en_drop_relock timeout got=%0d exp=1", M_counter);
      end
   endtask

   task automatic test_random();
      restart(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
              int'($urandom_range(12, 2)));
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(99, 0) == 0);
         if ($urandom_range(39, 0) == 0) en = ~en;
         if ($urandom_range(29, 0) == 0) N = 4'($urandom_range(15, 0));
         if ($urandom_range(29, 0) == 0) M = 2'($urandom_range(3, 0));
         if ($urandom_range(49, 0) == 0) ext_period = int'($urandom_range(12, 2));
         tick();
         vectors++;
         if (w_obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL random cyc=%0d got=%b exp=%b", i, w_obs, exp_vec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i <= S; i++) h[i] = 1'b0;
      m_run = 0; m_armed = 0; m_n = 0; m_m = 0; m_neff = 1; m_meff = 1; m_err = 0;
      rst = 1'b1; en = 1'b0; clk_ext = 1'b0; N = 4'd0; M = 2'd0;
      test_reset();
      test_nominal();
      test_mismatch();
      test_param_change();
      test_zero();
      test_en_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
